gameport_multi: RTL and testbench
=================================

Name: gameport_multi

Overview:
- Parametrised PC game-port (I/O 201h) emulator: turns host joystick data into one-shot axis timing bits and active-low button bits.
- Read by the CPU through the GPIO port.
- Generalises the fixed 2-stick/8-bit axis logic: joystick count and axis resolution are parameters.
- Adds axis snapshot at trigger, an explicit busy/timeout state machine, and optional digital-to-analog emulation.

Parameters:
- NUM_JOY, 2, number of joysticks (1..4); each has an X and a Y axis and two buttons.
- AXIS_W, 8, axis resolution in bits; axis values are two's complement, and the counter is AXIS_W bits.
- PRE_W, 4, width of the cpu_speed divider input.

Ports:
- clk_cpu  in  1  system/CPU clock.
- reset  in  1  asynchronous, active-high reset.
- gp_wr  in  1  one-cycle pulse: CPU write to the game port; fires all one-shots.
- cpu_speed  in  PRE_W  CPU slowdown code; count step period = (cpu_speed+1)*16 clocks.
- joy_swap  in  1  swaps joystick 0 and 1 (ignored when NUM_JOY=1).
- joy_digital  in  8*NUM_JOY  per stick: [0]right [1]left [2]down [3]up [4]btnA [5]btnB, active-high.
- joy_analog  in  2*AXIS_W*NUM_JOY  per stick lane: upper AXIS_W bits = X, lower = Y, signed.
- joy_digmode  in  NUM_JOY  per stick: use digital directions instead of analog (see Optional Feature).
- axis_out  out  2*NUM_JOY  bit 2j = X of stick j, bit 2j+1 = Y; 1 while the one-shot is running.
- btn_out  out  2*NUM_JOY  bit 2j = btnA, 2j+1 = btnB of stick j; active-low.
- busy  out  1  1 while in COUNT.

Behaviour:
- Reset values:
  - State IDLE.
  - axis_out = 0.
  - btn_out = all 1.
  - busy = 0.
  - Counter = 0; prescaler = 0.
- Swap: the logical stick index is applied before all other processing. With joy_swap=1, lanes 0 and 1 of both joy_digital and joy_analog exchange.
- Buttons:
  - btn_out is registered from the inverted button bits every clock, independent of state.
  - Latency is 1 clock.
- Axis mapping: mapped = {~v[AXIS_W-1], v[AXIS_W-2:0]}, so -2^(W-1) maps to 0, 0 maps to 2^(W-1), and max maps to 2^W-1.
- States: IDLE, COUNT, DONE.
  - Any -> COUNT on gp_wr, including a gp_wr during COUNT, which restarts. On this edge:
    - all mapped values are snapshotted into registers;
    - axis_out = all 1, counter = 0, prescaler = 0, busy = 1.
  - COUNT, per clock:
    - For each axis with snapshot == counter, clear its axis_out bit. The bit is visible low the cycle after the counter shows that value.
    - The prescaler increments. When prescaler == (cpu_speed+1)*16-1, the prescaler clears and the counter increments.
    - cpu_speed is sampled live, so a change takes effect at the next prescaler compare.
    - When counter == 2^AXIS_W-1 and the prescaler wraps: go to DONE, force axis_out = 0, busy = 0. The counter never wraps to 0.
  - DONE and IDLE: axis_out held 0; the counter is frozen. DONE and IDLE behave identically; DONE exists for debug visibility.
- Snapshots are stable for the whole measurement; joystick input changes mid-count do not affect the current one-shot.
- A reset asserted mid-count immediately returns all outputs to their reset values.
- Timing: an axis with mapped value m is first read low (m*P)+2 cycles after the gp_wr edge, where P = (cpu_speed+1)*16.

Optional Feature:
- Macro: GAMEPORT_DIGITAL_EMU_EN.
- When defined, a stick with joy_digmode[j]=1 replaces its analog lane by direction-derived values before the snapshot:
  - X: left only -> -2^(W-1); right only -> 2^(W-1)-1; none or both -> 0.
  - Y: up/down the same way (up = negative).
- When not defined:
  - joy_digmode is ignored.
  - Analog lanes are always used.
  - The emulation mux is not synthesised.

Test Plan:
1. Reset mid-count: assert reset during COUNT -> axis_out=0, busy=0, btn_out=all 1 in the same cycle; no activity until the next gp_wr.
2. NUM_JOY=2, AXIS_W=8, cpu_speed=0, stick0 X=0x00, Y=0x80, stick1 X=0x7F, Y=0xC0; pulse gp_wr -> axis_out=4'b1111 next cycle. Then:
   - bit1 (Y0, m=0) low at +2;
   - bit3 (Y1, m=0x40) low at +1026;
   - bit0 (X0, m=0x80) low at +2050;
   - bit2 (X1, m=0xFF) low at +4082;
   - busy falls at 256*16 cycles after the count starts.
3. Same stimulus, cpu_speed=1 -> every fall time in scenario 2 scales with P=32; change cpu_speed to 0 mid-count -> subsequent steps use P=16.
4. gp_wr again at cycle 500 of a count -> axis_out returns to 1111; all fall times are measured from the second pulse; values changed between the pulses are used.
5. joy_swap=1, stick0 btnA pressed -> btn_out=4'b1011 one cycle later; stick0 analog X=0x00 now drives bit2, not bit0.
6. With GAMEPORT_DIGITAL_EMU_EN defined, joy_digmode=01, stick0 left+down held, analog=0x7F7F -> X0 falls at +2, Y0 falls at +4082 (P=16). Without the macro -> both fall at +4082.

Source files
------------

// File: rtl/gameport_multi.sv
// Game-port (201h) emulator: one-shot axis timers and active-low buttons for NUM_JOY sticks.
// Define GAMEPORT_DIGITAL_EMU_EN to let a stick derive its axes from digital directions.
module gameport_multi #(
    parameter int NUM_JOY = 2,
    parameter int AXIS_W  = 8,
    parameter int PRE_W   = 4
) (
    input  logic                          clk_cpu,
    input  logic                          reset,
    input  logic                          gp_wr,
    input  logic [PRE_W-1:0]              cpu_speed,
    input  logic                          joy_swap,
    input  logic [8*NUM_JOY-1:0]          joy_digital,
    input  logic [2*AXIS_W*NUM_JOY-1:0]   joy_analog,
    input  logic [NUM_JOY-1:0]            joy_digmode,
    output logic [2*NUM_JOY-1:0]          axis_out,
    output logic [2*NUM_JOY-1:0]          btn_out,
    output logic                          busy
);
    // state  | meaning
    // IDLE   | no measurement since reset, axes low
    // COUNT  | one-shots running, counter stepping
    // DONE   | counter ran out, axes low (same as IDLE, kept for debug)
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam int PS_W = PRE_W + 4;

    logic [1:0]           state;
    logic [AXIS_W-1:0]    counter;
    logic [PS_W-1:0]      prescaler;
    logic [AXIS_W-1:0]    mapped [2*NUM_JOY];
    logic [AXIS_W-1:0]    snap   [2*NUM_JOY];
    logic [2*NUM_JOY-1:0] btn_next;
    logic                 unused_inputs;

    assign unused_inputs = ^{joy_digital, joy_digmode};

`ifdef GAMEPORT_DIGITAL_EMU_EN
    function automatic logic [AXIS_W-1:0] dir_val(input logic neg, input logic pos);
        if (neg && !pos)
            return {1'b1, {(AXIS_W-1){1'b0}}};
        else if (pos && !neg)
            return {1'b0, {(AXIS_W-1){1'b1}}};
        else
            return '0;
    endfunction
`endif

    for (genvar j = 0; j < NUM_JOY; j++) begin : g_lane
        // Only sticks 0 and 1 take part in the swap.
        localparam int SRC = (NUM_JOY > 1 && j < 2) ? (j ^ 1) : j;
        logic [5:0]        dig_l;
        logic [2*AXIS_W-1:0] ana_l;
        logic [AXIS_W-1:0] val_x;
        logic [AXIS_W-1:0] val_y;

        assign dig_l = joy_swap ? joy_digital[8*SRC +: 6] : joy_digital[8*j +: 6];
        assign ana_l = joy_swap ? joy_analog[2*AXIS_W*SRC +: 2*AXIS_W]
                                : joy_analog[2*AXIS_W*j +: 2*AXIS_W];
`ifdef GAMEPORT_DIGITAL_EMU_EN
        assign val_x = joy_digmode[j] ? dir_val(dig_l[1], dig_l[0]) : ana_l[2*AXIS_W-1 -: AXIS_W];
        assign val_y = joy_digmode[j] ? dir_val(dig_l[3], dig_l[2]) : ana_l[AXIS_W-1:0];
`else
        logic unused_dirs;
        assign unused_dirs = ^dig_l[3:0];
        assign val_x = ana_l[2*AXIS_W-1 -: AXIS_W];
        assign val_y = ana_l[AXIS_W-1:0];
`endif
        assign mapped[2*j]     = {~val_x[AXIS_W-1], val_x[AXIS_W-2:0]};
        assign mapped[2*j+1]   = {~val_y[AXIS_W-1], val_y[AXIS_W-2:0]};
        assign btn_next[2*j]   = ~dig_l[4];
        assign btn_next[2*j+1] = ~dig_l[5];
    end

    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            axis_out  <= '0;
            btn_out   <= '1;
            busy      <= 1'b0;
            counter   <= '0;
            prescaler <= '0;
            for (int i = 0; i < 2*NUM_JOY; i++)
                snap[i] <= '0;
        end else begin
            btn_out <= btn_next;
            if (gp_wr) begin
                state     <= S_COUNT;
                axis_out  <= '1;
                busy      <= 1'b1;
                counter   <= '0;
                prescaler <= '0;
                for (int i = 0; i < 2*NUM_JOY; i++)
                    snap[i] <= mapped[i];
            end else if (state == S_COUNT) begin
                for (int i = 0; i < 2*NUM_JOY; i++)
                    if (snap[i] == counter)
                        axis_out[i] <= 1'b0;
                // >= so a live drop of cpu_speed below the current prescaler still steps.
                if (prescaler >= {cpu_speed, 4'hF}) begin
                    prescaler <= '0;
                    if (counter == {AXIS_W{1'b1}}) begin
                        state    <= S_DONE;
                        axis_out <= '0;
                        busy     <= 1'b0;
                    end else begin
                        counter <= counter + AXIS_W'(1);
                    end
                end else begin
                    prescaler <= prescaler + PS_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_gameport_multi.sv
// Scoreboard bench for gameport_multi (NUM_JOY=2, AXIS_W=8): expected fall events queued, matched on output.
module tb_gameport_multi;
    localparam int BUSY_ID = 8;

    logic        clk_cpu = 1'b0;
    logic        reset = 1'b1;
    logic        gp_wr = 1'b0;
    logic [3:0]  cpu_speed = '0;
    logic        joy_swap = 1'b0;
    logic [15:0] joy_digital = '0;
    logic [31:0] joy_analog = '0;
    logic [1:0]  joy_digmode = '0;
    logic [3:0]  axis_out;
    logic [3:0]  btn_out;
    logic        busy;

    typedef struct {int id; int cyc;} ev_t;
    ev_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sw_cyc = -1;
    logic [3:0] sw_speed = '0;
    logic [3:0] prev_axis = '0;
    logic       prev_busy = 1'b0;

    gameport_multi #(.NUM_JOY(2), .AXIS_W(8), .PRE_W(4)) dut (
        .clk_cpu(clk_cpu), .reset(reset), .gp_wr(gp_wr), .cpu_speed(cpu_speed),
        .joy_swap(joy_swap), .joy_digital(joy_digital), .joy_analog(joy_analog),
        .joy_digmode(joy_digmode), .axis_out(axis_out), .btn_out(btn_out), .busy(busy)
    );

    always #5 clk_cpu = ~clk_cpu;

    // Edge (relative to the trigger edge) at which the counter first shows c.
    function automatic int step_edge(int c, int p1, int swc, int p2);
        if (c <= swc) return c * p1;
        return swc * p1 + (c - swc) * p2;
    endfunction

    task automatic push_ev(input int id, input int at);
        ev_t e;
        int  k;
        e.id = id;
        e.cyc = at;
        k = 0;
        while (k < exp_q.size() && exp_q[k].cyc <= at) k++;
        exp_q.insert(k, e);
    endtask

    task automatic push_axis(input int id, input logic [7:0] raw, input int p1, input int swc, input int p2);
        int s;
        s = $signed(raw);
        push_ev(id, step_edge(s + 128, p1, swc, p2) + 2);
    endtask

    task automatic push_busy(input int p1, input int swc, input int p2);
        push_ev(BUSY_ID, step_edge(256, p1, swc, p2) + 1);
    endtask

    task automatic pulse();
        gp_wr = 1'b1;
        @(posedge clk_cpu); #1;
        gp_wr = 1'b0;
        cyc = 1;
        checks++;
        if (axis_out !== 4'b1111 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pulse_start axis_out=%b busy=%b expected 1111/1", axis_out, busy);
        end
        prev_axis = axis_out;
        prev_busy = busy;
    endtask

    task automatic monitor(input int max_cyc);
        for (int n = 0; n < max_cyc; n++) begin
            @(posedge clk_cpu); #1;
            cyc++;
            if (cyc == sw_cyc) cpu_speed = sw_speed;
            for (int b = 0; b <= BUSY_ID; b++) begin
                logic fell, rose;
                if (b < 4) begin
                    fell = prev_axis[b] && !axis_out[b];
                    rose = !prev_axis[b] && axis_out[b];
                end else if (b == BUSY_ID) begin
                    fell = prev_busy && !busy;
                    rose = 1'b0;
                end else begin
                    fell = 1'b0;
                    rose = 1'b0;
                end
                if (rose) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rise bit=%0d at cyc=%0d", b, cyc);
                end
                if (fell) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_fall id=%0d at cyc=%0d, none expected", b, cyc);
                    end else begin
                        ev_t e;
                        e = exp_q.pop_front();
                        if (e.id !== b || e.cyc !== cyc) begin
                            errors++;
                            $display("FAIL fall_event got id=%0d cyc=%0d expected id=%0d cyc=%0d",
                                     b, cyc, e.id, e.cyc);
                        end
                    end
                end
            end
            prev_axis = axis_out;
            prev_busy = busy;
            if (!busy) break;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_cpu);
        #1;
        checks++;
        if (axis_out !== 4'b0000) begin errors++; $display("FAIL reset_axis axis_out=%b expected 0000", axis_out); end
        checks++;
        if (btn_out !== 4'b1111) begin errors++; $display("FAIL reset_btn btn_out=%b expected 1111", btn_out); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy busy=%b expected 0", busy); end
        reset = 1'b0;
        @(posedge clk_cpu); #1;
    endtask

    task automatic test_reset_mid_count();
        logic quiet;
        joy_analog = 32'h7F7F_7F7F;
        joy_digital = 16'h0010;
        pulse();
        monitor(100);
        checks++;
        if (btn_out !== 4'b1110) begin errors++; $display("FAIL mid_btn btn_out=%b expected 1110", btn_out); end
        #3 reset = 1'b1;
        #1;
        checks++;
        if (axis_out !== 4'b0000 || busy !== 1'b0 || btn_out !== 4'b1111) begin
            errors++;
            $display("FAIL mid_reset axis_out=%b busy=%b btn_out=%b expected 0000/0/1111", axis_out, busy, btn_out);
        end
        #2 reset = 1'b0;
        joy_digital = '0;
        @(posedge clk_cpu); #1;
        quiet = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk_cpu); #1;
            if (axis_out !== 4'b0000 || busy !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin errors++; $display("FAIL post_reset_quiet axis_out=%b busy=%b expected 0000/0", axis_out, busy); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL mid_drain pending=%0d expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_basic();
        joy_analog = {8'h7F, 8'hC0, 8'h00, 8'h80};
        cpu_speed = 4'd0;
        push_axis(0, 8'h00, 16, 256, 16);
        push_axis(1, 8'h80, 16, 256, 16);
        push_axis(2, 8'h7F, 16, 256, 16);
        push_axis(3, 8'hC0, 16, 256, 16);
        push_busy(16, 256, 16);
        pulse();
        monitor(9000);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL basic_drain pending=%0d expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_speed();
        joy_analog = {8'h7F, 8'hC0, 8'h00, 8'h80};
        cpu_speed = 4'd1;
        push_axis(0, 8'h00, 32, 256, 32);
        push_axis(1, 8'h80, 32, 256, 32);
        push_axis(2, 8'h7F, 32, 256, 32);
        push_axis(3, 8'hC0, 32, 256, 32);
        push_busy(32, 256, 32);
        pulse();
        monitor(9000);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL speed32_drain pending=%0d expected 0", exp_q.size()); exp_q.delete(); end
        // Drop to P=16 right after the counter reaches 64.
        cpu_speed = 4'd1;
        sw_cyc = 64 * 32 + 1;
        sw_speed = 4'd0;
        push_axis(0, 8'h00, 32, 64, 16);
        push_axis(1, 8'h80, 32, 64, 16);
        push_axis(2, 8'h7F, 32, 64, 16);
        push_axis(3, 8'hC0, 32, 64, 16);
        push_busy(32, 64, 16);
        pulse();
        monitor(9000);
        sw_cyc = -1;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL speed_switch_drain pending=%0d expected 0", exp_q.size()); exp_q.delete(); end
        cpu_speed = 4'd0;
    endtask

    task automatic test_restart();
        joy_analog = {8'h7F, 8'hC0, 8'h00, 8'h80};
        cpu_speed = 4'd0;
        push_axis(1, 8'h80, 16, 256, 16);
        pulse();
        monitor(498);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL restart_first_drain pending=%0d expected 0", exp_q.size()); exp_q.delete(); end
        joy_analog = {8'h80, 8'hFF, 8'h40, 8'h10};
        pulse();
        push_axis(0, 8'h40, 16, 256, 16);
        push_axis(1, 8'h10, 16, 256, 16);
        push_axis(2, 8'h80, 16, 256, 16);
        push_axis(3, 8'hFF, 16, 256, 16);
        push_busy(16, 256, 16);
        monitor(9000);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL restart_drain pending=%0d expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_swap();
        joy_swap = 1'b1;
        joy_digital = 16'h0010;
        joy_analog = {16'h8080, 16'h0000};
        #1;
        checks++;
        if (btn_out !== 4'b1111) begin errors++; $display("FAIL swap_btn_latency btn_out=%b expected 1111", btn_out); end
        @(posedge clk_cpu); #1;
        checks++;
        if (btn_out !== 4'b1011) begin errors++; $display("FAIL swap_btn btn_out=%b expected 1011", btn_out); end
        push_axis(0, 8'h80, 16, 256, 16);
        push_axis(1, 8'h80, 16, 256, 16);
        push_axis(2, 8'h00, 16, 256, 16);
        push_axis(3, 8'h00, 16, 256, 16);
        push_busy(16, 256, 16);
        pulse();
        monitor(9000);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL swap_drain pending=%0d expected 0", exp_q.size()); exp_q.delete(); end
        joy_swap = 1'b0;
        joy_digital = '0;
    endtask

    task automatic test_digital_emu();
        joy_digmode = 2'b01;
        joy_digital = 16'h0006;
        joy_analog = {16'h8080, 16'h7F7F};
`ifdef GAMEPORT_DIGITAL_EMU_EN
        push_axis(0, 8'h80, 16, 256, 16);
        push_axis(1, 8'h7F, 16, 256, 16);
`else
        push_axis(0, 8'h7F, 16, 256, 16);
        push_axis(1, 8'h7F, 16, 256, 16);
`endif
        push_axis(2, 8'h80, 16, 256, 16);
        push_axis(3, 8'h80, 16, 256, 16);
        push_busy(16, 256, 16);
        pulse();
        monitor(9000);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL digemu_drain pending=%0d expected 0", exp_q.size()); exp_q.delete(); end
        joy_digmode = '0;
        joy_digital = '0;
    endtask

    initial begin
        test_reset();
        test_reset_mid_count();
        test_basic();
        test_speed();
        test_restart();
        test_swap();
        test_digital_emu();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
